// File: rtl/acc_requant_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : acc_requant_pkg
//  Purpose  : Shared defaults, tracker state encoding and saturation helpers
//             for the accumulator requantisation stage.
//  Revision : 1.0  initial release
// ============================================================================
package acc_requant_pkg;

  localparam int DEF_ACC_WIDTH  = 51;
  localparam int DEF_NBITS      = 8;
  localparam int DEF_OUT_WIDTH  = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int SHIFT_W        = 6;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Largest value representable in a signed ow-bit activation
  function automatic longint sat_hi(input int ow);
    return (longint'(1) <<< (ow - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a signed ow-bit activation
  function automatic longint sat_lo(input int ow);
    return -(longint'(1) <<< (ow - 1));
  endfunction

endpackage : acc_requant_pkg
`default_nettype wire

// File: rtl/requant_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : requant_fifo
//  Purpose  : Small shift-register FIFO. Entry 0 is the head register and
//             drives the output directly; a push while full is dropped unless
//             a pop happens on the same edge.
//  Revision : 1.0  initial release
// ============================================================================
module requant_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop;
  logic             full;
  logic             accept;
  logic [CW-1:0]    wr_idx;

  // Handshake decode; a pop frees a slot for a same-edge push when full
  always_comb begin
    valid  = (count != '0);
    head   = mem[0];
    pop    = valid && ready;
    full   = (count == CW'(DEPTH));
    accept = push && (!full || pop);
    drop   = push && full && !pop;
    wr_idx = pop ? (count - CW'(1)) : count;
  end

  // Storage shifts toward the head on pop; slots past the fill level stay zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
        mem[DEPTH-1] <= '0;
      end
      if (accept) mem[wr_idx[AW-1:0]] <= din;
      count <= count + CW'(accept) - CW'(pop);
    end
  end

endmodule : requant_fifo
`default_nettype wire

// File: rtl/acc_requant.sv
`default_nettype none
// ============================================================================
//  Module   : acc_requant
//  Purpose  : Tracks shift-accumulator jobs, captures the final sum, applies a
//             rounding arithmetic right shift, optional ReLU and saturation,
//             and queues results behind a valid/ready output.
//  Revision : 1.0  initial release
// ============================================================================
module acc_requant
  import acc_requant_pkg::*;
#(
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int NBITS      = DEF_NBITS,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_acc,
  input  logic [ACC_WIDTH-1:0] nout,
  input  logic [SHIFT_W-1:0]   shift_amt,
  input  logic                 relu_en,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic                 overflow,
  output logic                 busy
);

  localparam int CNT_W = $clog2(NBITS + 3);
  localparam logic [CNT_W-1:0]   LAST_PSUM = CNT_W'(NBITS);
  localparam logic [CNT_W-1:0]   PEND_CYC  = CNT_W'(NBITS + 1);
  localparam logic [CNT_W-1:0]   CAP_CYC   = CNT_W'(NBITS + 2);
  localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(ACC_WIDTH - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH + 1)'(sat_hi(OUT_WIDTH));
  localparam logic signed [ACC_WIDTH:0] SAT_LO = (ACC_WIDTH + 1)'(sat_lo(OUT_WIDTH));

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               track_cap, latch_cfg, set_pend;

  logic [SHIFT_W-1:0] cfg_shift, pend_shift, cap_shift, shift_eff;
  logic               cfg_relu, pend_relu, cap_relu, pend_valid, cap_fire;

  logic signed [ACC_WIDTH:0] nout_ext, round_bias, round_sum, rounded;
  logic signed [ACC_WIDTH:0] s1_val, relu_val;
  logic                      s1_valid, s1_relu;
  logic [OUT_WIDTH-1:0]      sat_val;
  logic                      fifo_drop;

  // Tracker state register; cnt is the cycle index of the newest job
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: early restarts abort, late restarts leave the old capture alive
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    track_cap = 1'b0;
    latch_cfg = 1'b0;
    set_pend  = 1'b0;
    case (state)
      IDLE: begin
        if (start_acc) begin
          state_nxt = TRACK;
          cnt_nxt   = CNT_W'(1);
          latch_cfg = 1'b1;
        end
      end
      TRACK: begin
        track_cap = (cnt == CAP_CYC);
        if (start_acc) begin
          // Start at cycle NBITS+1: old capture is one cycle away, hand it off
          cnt_nxt   = CNT_W'(1);
          latch_cfg = 1'b1;
          set_pend  = (cnt == PEND_CYC);
        end else if (cnt == CAP_CYC) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Per-job config latches, plus a holding slot for a job superseded late
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_shift  <= '0;
      cfg_relu   <= 1'b0;
      pend_valid <= 1'b0;
      pend_shift <= '0;
      pend_relu  <= 1'b0;
    end else begin
      if (latch_cfg) begin
        cfg_shift <= shift_amt;
        cfg_relu  <= relu_en;
      end
      pend_valid <= set_pend;
      if (set_pend) begin
        pend_shift <= cfg_shift;
        pend_relu  <= cfg_relu;
      end
    end
  end

  // Stage 1: half-up rounding shift at one extra bit so the bias add is safe
  always_comb begin
    cap_fire   = track_cap | pend_valid;
    cap_shift  = pend_valid ? pend_shift : cfg_shift;
    cap_relu   = pend_valid ? pend_relu : cfg_relu;
    shift_eff  = (cap_shift > MAX_SHIFT) ? MAX_SHIFT : cap_shift;
    nout_ext   = {nout[ACC_WIDTH-1], nout};
    round_bias = (shift_eff == '0) ? '0
               : (ACC_WIDTH + 1)'(1) << (shift_eff - SHIFT_W'(1));
    round_sum  = nout_ext + round_bias;
    rounded    = round_sum >>> shift_eff;
  end

  // Capture register: samples the accumulator on its single valid cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s1_relu  <= 1'b0;
    end else begin
      s1_valid <= cap_fire;
      if (cap_fire) begin
        s1_val  <= rounded;
        s1_relu <= cap_relu;
      end
    end
  end

  // Stage 2: optional ReLU then clamp into the signed activation range
  always_comb begin
    relu_val = s1_val;
    if (s1_relu && s1_val[ACC_WIDTH]) relu_val = '0;
    if (relu_val > SAT_HI)      sat_val = SAT_HI[OUT_WIDTH-1:0];
    else if (relu_val < SAT_LO) sat_val = SAT_LO[OUT_WIDTH-1:0];
    else                        sat_val = relu_val[OUT_WIDTH-1:0];
  end

  requant_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid),
    .din   (sat_val),
    .ready (out_ready),
    .valid (out_valid),
    .head  (out_data),
    .drop  (fifo_drop)
  );

  // Sticky record that at least one result was lost to a full buffer
  always_ff @(posedge clk) begin
    if (rst)            overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
  end

  // Busy spans tracking, a handed-off capture, and the FIFO write cycle
  always_comb begin
    busy = (state == TRACK) || pend_valid || s1_valid;
  end

endmodule : acc_requant
`default_nettype wire

// File: tb/tb_acc_requant.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_requant
//  Purpose  : Self-checking bench for acc_requant with NBITS=3. A cycle
//             schedule is built up front; a reference model derives results,
//             buffer occupancy, overflow and busy from it, and a monitor
//             compares each accepted output against the expected queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_acc_requant;

  localparam int AW    = 51;
  localparam int NB    = 3;
  localparam int OW    = 8;
  localparam int DEPTH = 4;
  localparam int MAXC  = 1600;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_acc;
  logic [AW-1:0] nout;
  logic [5:0]    shift_amt;
  logic          relu_en;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_ready;
  logic          overflow;
  logic          busy;

  acc_requant #(
    .ACC_WIDTH (AW),
    .NBITS     (NB),
    .OUT_WIDTH (OW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_acc(start_acc),
    .nout     (nout),
    .shift_amt(shift_amt),
    .relu_en  (relu_en),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Cycle schedule
  bit         s_rst   [MAXC];
  bit         s_start [MAXC];
  bit         s_relu  [MAXC];
  bit         s_ready [MAXC];
  logic [5:0] s_shift [MAXC];
  longint     s_sum   [MAXC];
  longint     s_nout  [MAXC];
  int         ncyc;

  longint sbq[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cur_cycle = 0;
  bit     mon_en   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cur_cycle, act, exp);
    end
  endtask

  // Random signed value spanning the full accumulator width
  function automatic longint rand_acc();
    longint v;
    v = {$urandom, $urandom};
    v = (v <<< (64 - AW)) >>> (64 - AW);
    return v;
  endfunction

  // Reference: floor((sum + half) / 2^s), ReLU, clamp to [-128,127]
  function automatic longint ref_result(input longint sum, input int sh, input bit relu);
    int     s;
    longint d, num, q;
    s   = (sh > AW - 1) ? AW - 1 : sh;
    d   = longint'(1) << s;
    num = sum + ((s > 0) ? d / 2 : 0);
    q   = num / d;
    if (num < 0 && (num % d) != 0) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  // A job completes if no start lands in its cycles 1..NB and no reset hits it
  function automatic bit committed(input int s);
    if (!s_start[s]) return 1'b0;
    for (int a = s + 1; a <= s + NB; a++) if (s_start[a]) return 1'b0;
    for (int r = s; r <= s + NB + 3; r++) if (s_rst[r]) return 1'b0;
    return 1'b1;
  endfunction

  // Busy in cycle t if some live job is between its cycle 1 and its end
  function automatic bit busy_exp(input int t);
    int  lo, e;
    bit  killed;
    lo = (t - NB - 3 < 0) ? 0 : t - NB - 3;
    for (int s = lo; s < t; s++) begin
      if (!s_start[s]) continue;
      killed = 1'b0;
      for (int r = s; r < t; r++) if (s_rst[r]) killed = 1'b1;
      if (killed) continue;
      e = s + NB + 3;
      for (int a = s + 1; a <= s + NB; a++) begin
        if (s_start[a]) begin
          e = a;
          break;
        end
      end
      if (t <= e) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic job(input int t, input longint sum, input int sh, input bit relu);
    s_start[t]       = 1'b1;
    s_shift[t]       = 6'(sh);
    s_relu[t]        = relu;
    s_sum[t]         = sum;
    s_nout[t+NB+2]   = sum;
  endtask

  // Monitor: every accepted output is matched against the expected queue
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst && out_valid === 1'b1 && out_ready) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_data cycle %0d: got %0d, expected no output", cur_cycle,
                   longint'($signed(out_data)));
        end else begin
          check("out_data", longint'($signed(out_data)), sbq.pop_front());
        end
      end
    end
  end

  initial begin
    int t, bp0, rs0, k, sp, sh;
    int occ;
    bit ovf, pop, push;
    longint sum;

    rst = 1'b1; start_acc = 1'b0; nout = '0; shift_amt = '0; relu_en = 1'b0; out_ready = 1'b1;

    for (int i = 0; i < MAXC; i++) begin
      s_rst[i] = 1'b0; s_start[i] = 1'b0; s_relu[i] = 1'b0; s_ready[i] = 1'b1;
      s_shift[i] = '0; s_sum[i] = 0; s_nout[i] = rand_acc();
    end
    for (int i = 0; i < 3; i++) s_rst[i] = 1'b1;

    // Directed: basic, negative rounding with/without ReLU, saturation
    t = 5;
    job(t, 168, 2, 0);  t += 12;
    job(t, -7, 1, 0);   t += 10;
    job(t, -7, 1, 1);   t += 10;
    job(t, 700, 0, 0);  t += 10;
    job(t, -700, 0, 0); t += 10;
    job(t, 1000, 63, 0); t += 10;
    // Back-to-back at minimum spacing and one more, each with its own shift
    job(t, 1000, 3, 0); job(t + 4, 1000, 1, 0); job(t + 8, -555, 2, 1); job(t + 13, 37, 0, 0);
    t += 30;
    // Aborts in cycle 2, cycle 1 and cycle NB
    job(t, 99, 0, 0); job(t + 2, 44, 1, 0);   t += 15;
    job(t, 99, 0, 0); job(t + 1, -44, 1, 0);  t += 15;
    job(t, 99, 0, 0); job(t + NB, 60, 2, 0);  t += 15;
    // Backpressure: five jobs while the consumer stalls
    bp0 = t;
    for (int i = 0; i < 5; i++) job(bp0 + 4 * i, longint'(8 * (i + 1)), 1, 0);
    for (int c = bp0; c < bp0 + 32; c++) s_ready[c] = 1'b0;
    t = bp0 + 45;
    // Reset in cycle 3 of a job, then a normal job
    job(t, 168, 2, 0); s_rst[t + 3] = 1'b1; t += 12;
    job(t, -168, 2, 0); t += 12;
    // Random jobs with random spacing, config and consumer stalls
    rs0 = t;
    for (int i = 0; i < 90; i++) begin
      k = $urandom_range(0, 3);
      if (k < 2) begin
        sum = longint'($urandom_range(0, 4000)) - 2000;
        sh  = $urandom_range(0, 8);
      end else if (k == 2) begin
        sum = rand_acc();
        sh  = $urandom_range(40, 63);
      end else begin
        sum = rand_acc();
        sh  = $urandom_range(0, 63);
      end
      job(t, sum, sh, 1'($urandom_range(0, 1)));
      sp = $urandom_range(1, 8);
      t += sp;
    end
    for (int c = rs0; c < t + NB + 4; c++) s_ready[c] = ($urandom_range(0, 3) != 0);
    t += 40;
    ncyc = t;

    mon_en = 1'b1;
    occ = 0;
    ovf = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      cur_cycle = c;
      if (c > 0) begin
        check("out_valid", longint'(out_valid), longint'(occ > 0));
        check("overflow", longint'(overflow), longint'(ovf));
        check("busy", longint'(busy), longint'(busy_exp(c)));
        if (s_rst[c-1]) check("out_data_after_reset", longint'(out_data), 0);
      end
      rst       = s_rst[c];
      start_acc = s_start[c];
      shift_amt = s_shift[c];
      relu_en   = s_relu[c];
      out_ready = s_ready[c];
      nout      = s_nout[c][AW-1:0];
      // Buffer occupancy across the edge that ends this cycle
      if (s_rst[c]) begin
        occ = 0;
        ovf = 1'b0;
        sbq.delete();
      end else begin
        pop  = (occ > 0) && s_ready[c];
        push = (c - NB - 3 >= 0) && committed(c - NB - 3);
        if (push && occ == DEPTH && !pop) begin
          ovf = 1'b1;
        end else if (push) begin
          sbq.push_back(ref_result(s_sum[c-NB-3], int'(s_shift[c-NB-3]), s_relu[c-NB-3]));
          occ++;
        end
        if (pop) occ--;
      end
    end
    @(posedge clk);
    #1;
    cur_cycle = ncyc;
    check("queue_drained", longint'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_acc_requant
`default_nettype wire

// File: doc/acc_requant.md
# acc_requant

Downstream stage of the global shift-accumulator. It tracks each accumulation launched by `start_acc` and captures the accumulator's `nout` on the one cycle it holds the complete result. The captured value is scaled by a rounding arithmetic right shift, optionally ReLU'd, and saturated to a signed activation. Results are buffered in a small FIFO behind a valid/ready output toward the activation writeback path.

## Interface
Parameters:
- `ACC_WIDTH`, 51: width of `nout`, signed two's complement.
- `NBITS`, 8: bit-serial input cycles per accumulation (psum count).
- `OUT_WIDTH`, 8: signed output activation width.
- `FIFO_DEPTH`, 4: result buffer entries, power of two.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset. This is already decided.
- `start_acc`, in, 1: the same pulse driven to the accumulator.
- `nout`, in, ACC_WIDTH: accumulator output.
- `shift_amt`, in, 6: right-shift amount, latched on `start_acc`.
- `relu_en`, in, 1: clamp negatives to 0, latched on `start_acc`.
- `out_valid`, out, 1: FIFO head is valid.
- `out_data`, out, OUT_WIDTH: FIFO head value.
- `out_ready`, in, 1: consumer accepts the head.
- `overflow`, out, 1: sticky flag, set when a result is dropped because the FIFO is full.
- `busy`, out, 1: an accumulation or a capture is in flight.

## Operation
- States:
  - IDLE → TRACK on `start_acc`.
  - TRACK counts cycles. It issues the capture when the count reaches NBITS+2, then returns to IDLE, or stays in TRACK if a newer start is pending.
- Cycle numbering: `start_acc` is high in cycle 0, psums arrive in cycles 1..NBITS, and `nout` holds the final sum in cycle NBITS+2. Capture samples `nout` at the edge ending cycle NBITS+2.
- Restart rules:
  - `start_acc` in cycles 1..NBITS of an active job aborts that job. Nothing is written, and tracking restarts from the new start.
  - `start_acc` in cycle NBITS+1 or later does not abort. The old capture still fires and the new job is tracked concurrently, so the minimum spacing for back-to-back jobs is NBITS+1 cycles.
  - Each job uses the `shift_amt` and `relu_en` latched at its own start.
- Arithmetic:
  - Shift value is s = min(shift_amt, ACC_WIDTH-1).
  - Stage 1: r = (nout + (s>0 ? 1<<(s-1) : 0)) >>> s, computed at ACC_WIDTH+1 bits so the rounding add cannot overflow. Rounding is half-up toward +inf.
  - Stage 2: if relu_en and r<0 then r=0. The result then saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- FIFO:
  - Written at the end of stage 2. A write when full is dropped and sets `overflow`.
  - A pop occurs when `out_valid && out_ready`.
  - A simultaneous push and pop when full succeeds; nothing is dropped.
- `overflow` clears only on `rst`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `overflow`=0, `busy`=0. FIFO is emptied, pending jobs are cancelled, the state returns to IDLE, and latched config is cleared to 0.
- Reset mid-job: the job is lost and no write occurs.
- Latency: capture at the edge ending cycle NBITS+2, stage-2 register at NBITS+3, FIFO write at the edge ending NBITS+3. `out_valid` rises in cycle NBITS+4 if the FIFO was empty.
- `out_data` is driven from the FIFO head register, with no combinational path from `nout`.
- `out_valid` never depends combinationally on `out_ready`.
- `busy` is high from cycle 1 through the FIFO write cycle.

## Structure
- Package `acc_requant_pkg`:
  - default widths (ACC_WIDTH, NBITS, OUT_WIDTH),
  - state enum {IDLE, TRACK},
  - saturation bound constants derived from OUT_WIDTH.
- Sub-module `requant_fifo`: a synchronous FIFO with full/empty and a registered head.
- The top level holds the tracking counter(s), config latches, and the two-stage scale/saturate pipeline.

## Test plan
All scenarios use NBITS=3 with `out_ready`=1 unless stated.
- Basic: psums 24,24,24 with shift=2 (nout=168) → `out_data`=42, `out_valid` in cycle 7.
- Negative rounding: psums -1,-1,-1 (nout=-7) with shift=1 → -3; with `relu_en`=1 → 0.
- Saturation: psums 100,100,100 (nout=700) with shift=0 → 127. Psums -100 ×3 → -128.
- Back-to-back and abort:
  - starts spaced 4 cycles apart → two results in order, each with its own latched shift;
  - a start in cycle 2 → only the second job produces output.
- Backpressure: `out_ready`=0 for 5 jobs → 4 entries held, `overflow`=1. Releasing `out_ready` drains exactly 4 values in order, and `overflow` stays set.
- Reset: `rst` asserted in cycle 3 of a job → no output, all outputs 0. The next job completes normally.
